// File: rtl/branch_direction_predictor_pkg.sv
// Shared sizing constants, the IF/ID prediction bundle and the 2-bit counter step for the
// tournament branch direction predictor.
package branch_direction_predictor_pkg;

   localparam int history_depth          = 8;
   localparam int bht_s_index            = 8;
   localparam int tournament_pht_s_index = 8;
   localparam int perf_counter_width     = 32;

   localparam logic [1:0] ctr_reset_val = 2'b01;

   // Fields the predictor hands to the IF/ID pipeline register.
   typedef struct packed {
      logic [history_depth-1:0] local_pht_index;
      logic [history_depth-1:0] global_pht_index;
      logic                     local_pr;
      logic                     global_pr;
      logic                     br_pr;
   } bp_if_id_t;

   function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
      logic [1:0] nxt;
      nxt = ctr;
      if (up && ctr != 2'b11)
         nxt = ctr + 2'b01;
      else if (!up && ctr != 2'b00)
         nxt = ctr - 2'b01;
      return nxt;
   endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Array of 2-bit saturating counters: combinational read, clocked write, async reset to 2'b01.
module sat_counter_table
   import branch_direction_predictor_pkg::*;
#(
   parameter int index_width = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [index_width-1:0] rd_idx,
   output logic [1:0]             rd_ctr,
   input  logic                   wr_en,
   input  logic [index_width-1:0] wr_idx,
   input  logic                   wr_up
);

   localparam int depth = 1 << index_width;

   logic [1:0] ctr [depth];

   // Read sees the pre-write value in the same cycle; no bypass.
   assign rd_ctr = ctr[rd_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < depth; i++)
            ctr[i] <= ctr_reset_val;
      end else if (wr_en) begin
         ctr[wr_idx] <= sat_step(ctr[wr_idx], wr_up);
      end
   end

endmodule

// File: rtl/branch_direction_predictor.sv
// Tournament (local/global/chooser) branch direction predictor with zero-latency lookup.
// Optional macro BP_PERF_EN adds branch and mispredict counters.
module branch_direction_predictor
   import branch_direction_predictor_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              lookup_pc,
   output logic [history_depth-1:0] local_pht_index,
   output logic [history_depth-1:0] global_pht_index,
   output logic                     local_pr,
   output logic                     global_pr,
   output logic                     br_pr,
   input  logic                     update_valid,
   input  logic [31:0]              update_pc,
   input  logic [history_depth-1:0] update_local_idx,
   input  logic [history_depth-1:0] update_global_idx,
   input  logic                     update_local_pr,
   input  logic                     update_global_pr,
   input  logic                     update_br_pr,
   input  logic                     update_taken
`ifdef BP_PERF_EN
   ,
   output logic [perf_counter_width-1:0] perf_branch_count,
   output logic [perf_counter_width-1:0] perf_mispredict_count
`endif
);

   localparam int bht_depth = 1 << bht_s_index;

   logic [history_depth-1:0] ghr;
   logic [history_depth-1:0] bht [bht_depth];
   logic [1:0]               local_ctr;
   logic [1:0]               global_ctr;
   logic [1:0]               chooser_ctr;
   logic                     chooser_wr;
   bp_if_id_t                pred;

   always_comb begin
      pred                  = '0;
      pred.local_pht_index  = bht[lookup_pc[bht_s_index+1:2]];
      pred.global_pht_index = ghr ^ lookup_pc[history_depth+1:2];
      pred.local_pr         = local_ctr[1];
      pred.global_pr        = global_ctr[1];
      pred.br_pr            = chooser_ctr[1] ? local_ctr[1] : global_ctr[1];
   end

   assign local_pht_index  = pred.local_pht_index;
   assign global_pht_index = pred.global_pht_index;
   assign local_pr         = pred.local_pr;
   assign global_pr        = pred.global_pr;
   assign br_pr            = pred.br_pr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ghr <= '0;
         for (int i = 0; i < bht_depth; i++)
            bht[i] <= '0;
      end else if (update_valid) begin
         ghr <= {ghr[history_depth-2:0], update_taken};
         bht[update_pc[bht_s_index+1:2]] <=
            {bht[update_pc[bht_s_index+1:2]][history_depth-2:0], update_taken};
      end
   end

   sat_counter_table #(.index_width(history_depth)) u_local_pht (
      .clk    (clk),
      .rst    (rst),
      .rd_idx (pred.local_pht_index),
      .rd_ctr (local_ctr),
      .wr_en  (update_valid),
      .wr_idx (update_local_idx),
      .wr_up  (update_taken)
   );

   sat_counter_table #(.index_width(history_depth)) u_global_pht (
      .clk    (clk),
      .rst    (rst),
      .rd_idx (pred.global_pht_index),
      .rd_ctr (global_ctr),
      .wr_en  (update_valid),
      .wr_idx (update_global_idx),
      .wr_up  (update_taken)
   );

   // Chooser trains only when the components disagreed; up means "trust local".
   assign chooser_wr = update_valid && (update_local_pr != update_global_pr);

   sat_counter_table #(.index_width(tournament_pht_s_index)) u_chooser (
      .clk    (clk),
      .rst    (rst),
      .rd_idx (lookup_pc[tournament_pht_s_index+1:2]),
      .rd_ctr (chooser_ctr),
      .wr_en  (chooser_wr),
      .wr_idx (update_pc[tournament_pht_s_index+1:2]),
      .wr_up  (update_local_pr == update_taken)
   );

`ifdef BP_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_branch_count     <= '0;
         perf_mispredict_count <= '0;
      end else if (update_valid) begin
         perf_branch_count <= perf_branch_count + 1'b1;
         if (update_br_pr != update_taken)
            perf_mispredict_count <= perf_mispredict_count + 1'b1;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{lookup_pc[31:bht_s_index+2], lookup_pc[1:0],
                          update_pc[31:bht_s_index+2], update_pc[1:0]};
`else
   logic unused_bits;
   assign unused_bits = ^{lookup_pc[31:bht_s_index+2], lookup_pc[1:0],
                          update_pc[31:bht_s_index+2], update_pc[1:0], update_br_pr};
`endif

endmodule

// File: tb/tb_branch_direction_predictor.sv
// Self-checking bench for branch_direction_predictor; define BP_PERF_EN to also check the
// performance counters.
module tb_branch_direction_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] lookup_pc;
   logic [7:0]  local_pht_index;
   logic [7:0]  global_pht_index;
   logic        local_pr;
   logic        global_pr;
   logic        br_pr;
   logic        update_valid;
   logic [31:0] update_pc;
   logic [7:0]  update_local_idx;
   logic [7:0]  update_global_idx;
   logic        update_local_pr;
   logic        update_global_pr;
   logic        update_br_pr;
   logic        update_taken;
`ifdef BP_PERF_EN
   logic [31:0] perf_branch_count;
   logic [31:0] perf_mispredict_count;
`endif

   logic [31:0] exp_q[$];
   logic [31:0] got;
   logic [31:0] exp_v;
   int          vectors;
   int          miscompares;

   branch_direction_predictor dut (
      .clk               (clk),
      .rst               (rst),
      .lookup_pc         (lookup_pc),
      .local_pht_index   (local_pht_index),
      .global_pht_index  (global_pht_index),
      .local_pr          (local_pr),
      .global_pr         (global_pr),
      .br_pr             (br_pr),
      .update_valid      (update_valid),
      .update_pc         (update_pc),
      .update_local_idx  (update_local_idx),
      .update_global_idx (update_global_idx),
      .update_local_pr   (update_local_pr),
      .update_global_pr  (update_global_pr),
      .update_br_pr      (update_br_pr),
      .update_taken      (update_taken)
`ifdef BP_PERF_EN
      ,
      .perf_branch_count     (perf_branch_count),
      .perf_mispredict_count (perf_mispredict_count)
`endif
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] pk(input logic [7:0] li, input logic [7:0] gi,
                                      input logic lp, input logic gp, input logic bp);
      return {13'd0, li, gi, lp, gp, bp};
   endfunction

   function automatic logic [31:0] obs();
      return {13'd0, local_pht_index, global_pht_index, local_pr, global_pr, br_pr};
   endfunction

   // driver tasks
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      update_valid = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   task automatic do_update(input logic [31:0] pc, input logic [7:0] li, input logic [7:0] gi,
                            input logic lp, input logic gp, input logic bp, input logic tk);
      @(negedge clk);
      update_valid      = 1'b1;
      update_pc         = pc;
      update_local_idx  = li;
      update_global_idx = gi;
      update_local_pr   = lp;
      update_global_pr  = gp;
      update_br_pr      = bp;
      update_taken      = tk;
      @(posedge clk);
      #1;
      update_valid = 1'b0;
   endtask

   task automatic set_lookup(input logic [31:0] pc);
      @(negedge clk);
      lookup_pc = pc;
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] pi;
      apply_reset();
      set_lookup(32'h60);
      exp_q.push_back(pk(8'h00, 8'h18, 1'b0, 1'b0, 1'b0));
      got = obs(); exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin
         miscompares++; $display("FAIL reset_lookup got=%h exp=%h", got, exp_v);
      end
      for (int i = 0; i < 4; i++) begin
         pi = 8'($urandom_range(0, 255));
         set_lookup({22'd0, pi, 2'b00});
         exp_q.push_back(pk(8'h00, pi, 1'b0, 1'b0, 1'b0));
         got = obs(); exp_v = exp_q.pop_front(); vectors++;
         if (got !== exp_v) begin
            miscompares++; $display("FAIL reset_rand_lookup got=%h exp=%h", got, exp_v);
         end
      end
   endtask

   task automatic test_idle();
      apply_reset();
      @(negedge clk);
      update_pc = 32'h60; update_local_idx = 8'h00; update_global_idx = 8'h18;
      update_local_pr = 1'b1; update_global_pr = 1'b0; update_br_pr = 1'b0;
      update_taken = 1'b1; update_valid = 1'b0;
      repeat (3) @(posedge clk);
      set_lookup(32'h60);
      exp_q.push_back(pk(8'h00, 8'h18, 1'b0, 1'b0, 1'b0));
      got = obs(); exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin
         miscompares++; $display("FAIL idle_no_update got=%h exp=%h", got, exp_v);
      end
   endtask

   task automatic test_local_pht();
      logic [7:0] exp_gi [4] = '{8'hDF, 8'h3E, 8'hFC, 8'h43};
      logic       exp_lp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      apply_reset();
      // Make BHT[0x80] = 0x05 so lookups at pc 0x200 read local PHT entry 0x05.
      do_update(32'h200, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
      do_update(32'h200, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_update(32'h200, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int step = 0; step < 4; step++) begin
         case (step)
            0: repeat (4) do_update(32'h100, 8'h05, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
            1: do_update(32'h100, 8'h05, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
            2: do_update(32'h100, 8'h05, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
            default: begin
               repeat (2) do_update(32'h100, 8'h05, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
               repeat (2) do_update(32'h100, 8'h05, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
            end
         endcase
         set_lookup(32'h200);
         exp_q.push_back(pk(8'h05, exp_gi[step], exp_lp[step], 1'b0, 1'b0));
         got = obs(); exp_v = exp_q.pop_front(); vectors++;
         if (got !== exp_v) begin
            miscompares++; $display("FAIL local_pht_step%0d got=%h exp=%h", step, got, exp_v);
         end
      end
   endtask

   task automatic test_chooser();
      // Local correct: chooser 01 -> 10, final prediction follows local (0) not global (1).
      apply_reset();
      do_update(32'h60, 8'h10, 8'h19, 1'b1, 1'b0, 1'b0, 1'b1);
      set_lookup(32'h60);
      exp_q.push_back(pk(8'h01, 8'h19, 1'b0, 1'b1, 1'b0));
      got = obs(); exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin
         miscompares++; $display("FAIL chooser_local got=%h exp=%h", got, exp_v);
      end
      // Agreement leaves chooser at 01, so global wins.
      apply_reset();
      do_update(32'h60, 8'h10, 8'h19, 1'b1, 1'b1, 1'b1, 1'b1);
      set_lookup(32'h60);
      exp_q.push_back(pk(8'h01, 8'h19, 1'b0, 1'b1, 1'b1));
      got = obs(); exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin
         miscompares++; $display("FAIL chooser_agree got=%h exp=%h", got, exp_v);
      end
      // Global correct first (chooser -> 00), then global must still win.
      apply_reset();
      do_update(32'h60, 8'hF0, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
      do_update(32'h60, 8'h10, 8'h19, 1'b0, 1'b0, 1'b0, 1'b1);
      set_lookup(32'h60);
      exp_q.push_back(pk(8'h01, 8'h19, 1'b0, 1'b1, 1'b1));
      got = obs(); exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin
         miscompares++; $display("FAIL chooser_global got=%h exp=%h", got, exp_v);
      end
   endtask

   task automatic test_same_cycle();
      apply_reset();
      @(negedge clk);
      lookup_pc = 32'h60;
      update_valid = 1'b1; update_pc = 32'h60;
      update_local_idx = 8'hF0; update_global_idx = 8'hF0;
      update_local_pr = 1'b0; update_global_pr = 1'b0; update_br_pr = 1'b0;
      update_taken = 1'b1;
      exp_q.push_back(pk(8'h00, 8'h18, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(pk(8'h01, 8'h19, 1'b0, 1'b0, 1'b0));
      #1;
      got = obs(); exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin
         miscompares++; $display("FAIL same_cycle_pre got=%h exp=%h", got, exp_v);
      end
      @(posedge clk);
      #1;
      update_valid = 1'b0;
      #1;
      got = obs(); exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin
         miscompares++; $display("FAIL same_cycle_post got=%h exp=%h", got, exp_v);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      lookup_pc = 32'h60;
      for (int i = 0; i < 9; i++)
         do_update({22'd0, 8'($urandom_range(0, 255)), 2'b00},
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      do_update(32'h60, 8'h00, 8'h19, 1'b1, 1'b0, 1'b0, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      exp_q.push_back(pk(8'h00, 8'h18, 1'b0, 1'b0, 1'b0));
      got = obs(); exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin
         miscompares++; $display("FAIL reset_async got=%h exp=%h", got, exp_v);
      end
      // Updates presented while held in reset must be dropped.
      update_valid = 1'b1; update_pc = 32'h60; update_taken = 1'b1;
      update_local_idx = 8'h00; update_global_idx = 8'h18;
      repeat (2) @(posedge clk);
      @(negedge clk);
      update_valid = 1'b0;
      rst = 1'b1;
      #1;
      exp_q.push_back(pk(8'h00, 8'h18, 1'b0, 1'b0, 1'b0));
      got = obs(); exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin
         miscompares++; $display("FAIL reset_ignores_update got=%h exp=%h", got, exp_v);
      end
   endtask

`ifdef BP_PERF_EN
   task automatic test_perf();
      apply_reset();
      #1;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      got = perf_branch_count; exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin
         miscompares++; $display("FAIL perf_branch_reset got=%0d exp=%0d", got, exp_v);
      end
      got = perf_mispredict_count; exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin
         miscompares++; $display("FAIL perf_mispredict_reset got=%0d exp=%0d", got, exp_v);
      end
      do_update(32'h40, 8'h01, 8'h02, 1'b1, 1'b1, 1'b1, 1'b1);
      do_update(32'h44, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
      do_update(32'h48, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(32'd3);
      exp_q.push_back(32'd1);
      got = perf_branch_count; exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin
         miscompares++; $display("FAIL perf_branch got=%0d exp=%0d", got, exp_v);
      end
      got = perf_mispredict_count; exp_v = exp_q.pop_front(); vectors++;
      if (got !== exp_v) begin
         miscompares++; $display("FAIL perf_mispredict got=%0d exp=%0d", got, exp_v);
      end
   endtask
`endif

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b0;
      lookup_pc = 32'h0;
      update_valid = 1'b0;
      update_pc = 32'h0;
      update_local_idx = 8'h0;
      update_global_idx = 8'h0;
      update_local_pr = 1'b0;
      update_global_pr = 1'b0;
      update_br_pr = 1'b0;
      update_taken = 1'b0;
      #12;
      rst = 1'b1;
      test_reset();
      test_idle();
      test_local_pht();
      test_chooser();
      test_same_cycle();
      test_reset_mid();
`ifdef BP_PERF_EN
      test_perf();
`endif
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/branch_direction_predictor.md
BRANCH_DIRECTION_PREDICTOR -- requirements
Module: branch_direction_predictor

Interface
REQ-001 Parameter history_depth, 8, history bits per BHT entry and GHR; equals PHT index width.
REQ-002 Parameter bht_s_index, 8, BHT and chooser index width; index = pc[bht_s_index+1:2].
REQ-003 Parameter tournament_pht_s_index, 8, chooser table index width.
REQ-004 Port clk  in  1  sole clock, rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-low.
REQ-006 Port lookup_pc  in  32  IF-stage PC.
REQ-007 Port local_pht_index  out  8  local PHT index used for this lookup.
REQ-008 Port global_pht_index  out  8  global PHT index used for this lookup.
REQ-009 Port local_pr / global_pr / br_pr  out  1 each  local, global and final taken prediction.
REQ-010 Port update_valid  in  1  a resolved conditional branch is presented this cycle.
REQ-011 Port update_pc  in  32  PC of the resolved branch.
REQ-012 Port update_local_idx / update_global_idx  in  8 each  indices carried down the pipe from lookup.
REQ-013 Port update_local_pr / update_global_pr / update_br_pr  in  1 each  predictions carried from lookup.
REQ-014 Port update_taken  in  1  actual branch outcome.
REQ-015 Ports perf_branch_count / perf_mispredict_count  out  32 each; present only with BP_PERF_EN.

Function
REQ-016 State: GHR (8b), BHT (256x8b), local PHT (256x2b), global PHT (256x2b), chooser (256x2b).
REQ-017 Lookup is combinational, zero latency: local_pht_index = BHT[lookup_pc[9:2]]; global_pht_index = GHR ^ lookup_pc[9:2].
REQ-018 local_pr = localPHT[local_pht_index][1]; global_pr = globalPHT[global_pht_index][1].
REQ-019 br_pr = local_pr when chooser[lookup_pc[9:2]][1] = 1, else global_pr.
REQ-020 All updates commit on the rising clk edge when update_valid = 1; nothing changes when update_valid = 0.
REQ-021 BHT[update_pc[9:2]] <= {old[6:0], update_taken}; GHR <= {GHR[6:0], update_taken}.
REQ-022 localPHT[update_local_idx] and globalPHT[update_global_idx] increment if taken, else decrement; saturate at 3 and 0.
REQ-023 Chooser updates only when update_local_pr != update_global_pr: increment (saturate 3) if local correct, decrement (saturate 0) if global correct.
REQ-024 Same-cycle lookup and update of the same entry: lookup reflects pre-update state; new value is visible the following cycle; no bypass.
REQ-025 Index wrap: all index arithmetic is modulo 256; the XOR never carries.

Reset
REQ-026 rst low clears GHR and BHT to 0 and sets every PHT and chooser entry to 2'b01, immediately and independent of clk.
REQ-027 While rst is low, update_valid is ignored; after reset, lookup_pc=X yields local_pr=global_pr=br_pr=0.
REQ-028 Perf counters (when present) reset to 0; reset mid-update discards that update.

Configuration
REQ-029 Macro BP_PERF_EN defined: perf_branch_count increments on every update_valid, and perf_mispredict_count increments when update_br_pr != update_taken; both wrap modulo 2^32.
REQ-030 BP_PERF_EN undefined: both counters and their ports are absent; prediction behaviour is identical.

Structure
REQ-031 history_depth, bht_s_index, tournament_pht_s_index and perf_counter_width live in rv32i_types; the predictor outputs map directly onto if_id_pipeline_reg fields.
REQ-032 One sub-module, sat_counter_table (parameterised 2-bit saturating counter array, async read, sync write, async reset to 2'b01), instantiated three times.

Verification
REQ-033 Reset, lookup_pc=0x60 -> local_pht_index=0x00, global_pht_index=0x18, local_pr=global_pr=br_pr=0.
REQ-034 Four taken updates to update_local_idx=0x05, then one not-taken -> counter 3 then 2; a lookup hitting idx 0x05 gives local_pr=1.
REQ-035 Update pc=0x60, local_pr=1, global_pr=0, taken=1 -> chooser[0x18] 01->10; next lookup at 0x60 returns br_pr=local_pr.
REQ-036 Update and lookup at pc=0x60 in the same cycle -> local_pht_index=0x00 that cycle, 0x01 the next (taken).
REQ-037 rst pulled low between edges after 10 updates -> outputs return to reset values before the next edge.
REQ-038 BP_PERF_EN: three updates, one with update_br_pr != update_taken -> counts 3 and 1; without the macro, the bench compiles without the perf ports.
